// File: rtl/smpl_iter_gen.sv
// rtl/smpl_iter_gen.sv - walks a snapped bounding box in raster order, one sample per cycle
module smpl_iter_gen #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]             color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]               box_R13S,
  input  logic                                      validTri_R13H,
  output logic                                      halt_R13L,
  input  logic [3:0]                                subSample_RnnnnU,
  input  logic                                      ds_stall_R14H,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]             color_R14U,
  output logic [1:0][SIGFIG-1:0]                    sample_R14S,
  output logic                                      validSamp_R14H,
  output logic [31:0]                               smpl_cnt_R14U,
  output logic                                      cnt_valid_R14H
);

  localparam int W = SIGFIG + 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WALK = 1'b1;

  logic [0:0]              state;
  logic signed [W-1:0]     ll_x, ur_x, ur_y, step_q;
  logic signed [W-1:0]     cur_x, cur_y;
  logic [31:0]             cnt;
  // An empty box accepted on the same edge another triangle finishes owes a zero-count pulse next cycle
  logic                    pend_zero;

  logic [1:0]              ss_lg2;
  logic signed [W-1:0]     step_in;
  logic signed [W-1:0]     in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  logic signed [W-1:0]     nx, ny;
  logic                    adv_x, adv_y, last, finish, accept, empty_in;

  always_comb begin
    ss_lg2 = 2'd0;
    if (subSample_RnnnnU[0])      ss_lg2 = 2'd3;
    else if (subSample_RnnnnU[1]) ss_lg2 = 2'd2;
    else if (subSample_RnnnnU[2]) ss_lg2 = 2'd1;
    step_in = W'(1) << (RADIX - 32'(ss_lg2));
  end

  // Widen by one bit so x+step never wraps before the compare
  assign in_ll_x  = {box_R13S[0][0][SIGFIG-1], box_R13S[0][0]};
  assign in_ll_y  = {box_R13S[0][1][SIGFIG-1], box_R13S[0][1]};
  assign in_ur_x  = {box_R13S[1][0][SIGFIG-1], box_R13S[1][0]};
  assign in_ur_y  = {box_R13S[1][1][SIGFIG-1], box_R13S[1][1]};
  assign empty_in = (in_ll_x > in_ur_x) || (in_ll_y > in_ur_y);

  assign nx     = cur_x + step_q;
  assign ny     = cur_y + step_q;
  assign adv_x  = (nx <= ur_x);
  assign adv_y  = (ny <= ur_y);
  assign last   = !adv_x && !adv_y;
  assign finish = (state == ST_WALK) && last && !ds_stall_R14H;

  assign halt_R13L = (state == ST_IDLE) || (last && !ds_stall_R14H);
  assign accept    = validTri_R13H && halt_R13L;

  assign sample_R14S[0] = cur_x[SIGFIG-1:0];
  assign sample_R14S[1] = cur_y[SIGFIG-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      step_q         <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      cnt            <= '0;
      pend_zero      <= 1'b0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      validSamp_R14H <= 1'b0;
      smpl_cnt_R14U  <= '0;
      cnt_valid_R14H <= 1'b0;
    end else begin
      cnt_valid_R14H <= 1'b0;
      if (pend_zero) begin
        cnt_valid_R14H <= 1'b1;
        smpl_cnt_R14U  <= '0;
        pend_zero      <= 1'b0;
      end
      if (finish) begin
        cnt_valid_R14H <= 1'b1;
        smpl_cnt_R14U  <= cnt;
      end

      if (accept) begin
        tri_R14S   <= tri_R13S;
        color_R14U <= color_R13U;
        ll_x       <= in_ll_x;
        ur_x       <= in_ur_x;
        ur_y       <= in_ur_y;
        step_q     <= step_in;
        if (empty_in) begin
          state          <= ST_IDLE;
          validSamp_R14H <= 1'b0;
          if (finish || pend_zero) begin
            pend_zero <= 1'b1;
          end else begin
            cnt_valid_R14H <= 1'b1;
            smpl_cnt_R14U  <= '0;
          end
        end else begin
          state          <= ST_WALK;
          validSamp_R14H <= 1'b1;
          cur_x          <= in_ll_x;
          cur_y          <= in_ll_y;
          cnt            <= 32'd1;
        end
      end else if (finish) begin
        state          <= ST_IDLE;
        validSamp_R14H <= 1'b0;
      end else if (state == ST_WALK && !ds_stall_R14H) begin
        if (adv_x) begin
          cur_x <= nx;
        end else begin
          cur_x <= ll_x;
          cur_y <= ny;
        end
        if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_smpl_iter_gen.sv
// tb/tb_smpl_iter_gen.sv - randomized bench for smpl_iter_gen against a queue-based sample model
module tb_smpl_iter_gen;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk, rst;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S, tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U, color_R14U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                   validTri_R13H, halt_R13L, ds_stall_R14H;
  logic [3:0]                             subSample_RnnnnU;
  logic [1:0][SIGFIG-1:0]                 sample_R14S;
  logic                                   validSamp_R14H, cnt_valid_R14H;
  logic [31:0]                            smpl_cnt_R14U;

  smpl_iter_gen dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_R13S), .color_R13U(color_R13U),
    .box_R13S(box_R13S), .validTri_R13H(validTri_R13H), .halt_R13L(halt_R13L),
    .subSample_RnnnnU(subSample_RnnnnU), .ds_stall_R14H(ds_stall_R14H),
    .tri_R14S(tri_R14S), .color_R14U(color_R14U), .sample_R14S(sample_R14S),
    .validSamp_R14H(validSamp_R14H), .smpl_cnt_R14U(smpl_cnt_R14U),
    .cnt_valid_R14H(cnt_valid_R14H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0, rand_stall = 0, m_accepted = 0;
  int q_x[$], q_y[$], pulse_q[$], pulses_seen[$];
  int m_n = 0;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] m_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          m_color;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int step_of(logic [3:0] m);
    int lg2;
    lg2 = m[0] ? 3 : m[1] ? 2 : m[2] ? 1 : 0;
    return 1 << (10 - lg2);
  endfunction

  // Model: the queue holds every sample of the current triangle still to be shown; head is on the output
  always @(posedge clk) begin
    m_accepted = 0;
    if (!rst) begin
      q_x.delete(); q_y.delete(); pulse_q.delete();
    end else begin
      bit can;
      can = (q_x.size() == 0) || (q_x.size() == 1 && !ds_stall_R14H);
      if (q_x.size() > 0 && !ds_stall_R14H) begin
        void'(q_x.pop_front()); void'(q_y.pop_front());
        if (q_x.size() == 0) pulse_q.push_back(m_n);
      end
      if (can && validTri_R13H) begin
        int llx, lly, urx, ury, st;
        m_accepted = 1;
        llx = $signed(box_R13S[0][0]); lly = $signed(box_R13S[0][1]);
        urx = $signed(box_R13S[1][0]); ury = $signed(box_R13S[1][1]);
        st  = step_of(subSample_RnnnnU);
        for (int y = lly; y <= ury; y += st)
          for (int x = llx; x <= urx; x += st) begin
            q_x.push_back(x); q_y.push_back(y);
          end
        m_n = q_x.size();
        m_tri = tri_R13S; m_color = color_R13U;
        if (m_n == 0) pulse_q.push_back(0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("halt", halt_R13L, (q_x.size() == 0) || (q_x.size() == 1 && !ds_stall_R14H));
      chk("valid", validSamp_R14H, q_x.size() > 0);
      if (q_x.size() > 0) begin
        chk("sample_x", $signed(sample_R14S[0]), q_x[0]);
        chk("sample_y", $signed(sample_R14S[1]), q_y[0]);
        chk("tri", tri_R14S == m_tri, 1);
        chk("color", color_R14U == m_color, 1);
      end
      if (cnt_valid_R14H) begin
        pulses_seen.push_back(int'(smpl_cnt_R14U));
        chk("pulse_expected", pulse_q.size() > 0, 1);
        if (pulse_q.size() > 0) chk("pulse_count", smpl_cnt_R14U, pulse_q.pop_front());
      end
      chk("pulse_lag", pulse_q.size() <= 1, 1);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_stall) ds_stall_R14H = ($urandom % 4 == 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(logic [3:0] mode, int llx, int lly, int urx, int ury);
    int n;
    subSample_RnnnnU = mode;
    box_R13S[0][0] = SIGFIG'(llx); box_R13S[0][1] = SIGFIG'(lly);
    box_R13S[1][0] = SIGFIG'(urx); box_R13S[1][1] = SIGFIG'(ury);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_R13S[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++) color_R13U[c] = SIGFIG'($urandom);
    validTri_R13H = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_accepted && n < 300);
    chk("accept_timeout", m_accepted, 1);
    validTri_R13H = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_x.size() != 0 || pulse_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 500, 1);
    tick();
  endtask

  initial begin
    int np;
    rst = 1'b0; validTri_R13H = 1'b0; ds_stall_R14H = 1'b0;
    subSample_RnnnnU = 4'b1000; box_R13S = '0; tri_R13S = '0; color_R13U = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", validSamp_R14H, 0);
    chk("rst_halt", halt_R13L, 1);
    chk("rst_cnt", smpl_cnt_R14U, 0);
    chk("rst_cnt_valid", cnt_valid_R14H, 0);
    chk("rst_sample", sample_R14S, 0);
    chk("rst_tri", tri_R14S == '0, 1);
    chk_en = 1;
    tick();

    present(4'b1000, 0, 0, 2048, 1024);
    chk("pin_six", q_x.size(), 6);
    chk("pin_x3", q_x[3], 0);
    chk("pin_y3", q_y[3], 1024);
    wait_idle();
    chk("six_count", pulses_seen[pulses_seen.size()-1], 6);

    present(4'b0001, 512, 512, 512, 512);
    chk("pin_one", q_x.size(), 1);
    wait_idle();
    chk("one_count", pulses_seen[pulses_seen.size()-1], 1);

    np = pulses_seen.size();
    present(4'b1000, 1024, 0, 0, 0);
    chk("pin_empty", q_x.size(), 0);
    wait_idle();
    chk("empty_pulses", pulses_seen.size(), np + 1);
    chk("empty_count", pulses_seen[pulses_seen.size()-1], 0);

    np = pulses_seen.size();
    present(4'b1000, 0, 0, 3072, 0);
    present(4'b1000, 0, 0, 0, 1024);
    wait_idle();
    chk("b2b_pulses", pulses_seen.size(), np + 2);
    chk("b2b_first", pulses_seen[np], 4);
    chk("b2b_second", pulses_seen[np+1], 2);

    np = pulses_seen.size();
    present(4'b1000, 0, 0, 3072, 0);
    tick();
    ds_stall_R14H = 1'b1;
    repeat (3) tick();
    chk("stall_held_x", $signed(sample_R14S[0]), 1024);
    rst = 1'b0; ds_stall_R14H = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_no_pulse", pulses_seen.size(), np);
    chk("rst_idle_halt", halt_R13L, 1);
    chk("rst_tri_clear", tri_R14S == '0, 1);
    chk("rst_cnt_clear", smpl_cnt_R14U, 0);

    rand_stall = 1;
    for (int t = 0; t < 150; t++) begin
      logic [3:0] mode;
      int st, llx, lly, urx, ury;
      mode = 4'b0001 << $urandom_range(0, 3);
      st   = step_of(mode);
      llx  = ($urandom_range(0, 8) - 4) * st;
      lly  = ($urandom_range(0, 8) - 4) * st;
      urx  = llx + ($urandom_range(1, 4) - 1) * st;
      ury  = lly + ($urandom_range(1, 3) - 1) * st;
      if ($urandom % 10 == 0) urx = llx - st;
      if ($urandom % 10 == 0) ury = lly - st;
      present(mode, llx, lly, urx, ury);
      repeat ($urandom_range(0, 1) * $urandom_range(0, 3)) tick();
    end
    rand_stall = 0;
    ds_stall_R14H = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("drain_pulses", pulse_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
